// File: rtl/sdram_rd_scoreboard_if.sv
// sdram_rd_scoreboard_if: expected-entry push channel and read-response channel
// between the SDRAM host port (master) and the read scoreboard (slave).
interface sdram_rd_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();
   logic                  exp_valid;
   logic [DATA_W-1:0]     exp_data;
   logic [DATA_W/8-1:0]   exp_mask;
   logic [ADDR_W-1:0]     exp_addr;
   logic                  exp_ready;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_data;
   modport master (
      output exp_valid, exp_data, exp_mask, exp_addr, rsp_valid, rsp_data,
      input  exp_ready
   );
   modport slave (
      input  exp_valid, exp_data, exp_mask, exp_addr, rsp_valid, rsp_data,
      output exp_ready
   );
endinterface

// File: rtl/sdram_rd_scoreboard.sv
// sdram_rd_scoreboard: in-order expected-data FIFO that compares each returned
// read word byte-wise against the oldest accepted request.
module sdram_rd_scoreboard #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   sdram_rd_scoreboard_if.slave    bus,
   input  logic                    clear_i,
   output logic                    cmp_valid_o,
   output logic                    mismatch_o,
   output logic [DATA_W/8-1:0]     mismatch_bytes_o,
   output logic [ADDR_W-1:0]       mismatch_addr_o,
   output logic [CNT_W-1:0]        match_count_o,
   output logic [CNT_W-1:0]        mismatch_count_o,
   output logic [CNT_W-1:0]        skip_count_o,
   output logic                    overflow_o,
   output logic                    underflow_o,
   output logic [$clog2(DEPTH):0]  occupancy_o,
   output logic                    idle_o
);
   localparam int NB = DATA_W / 8;
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [NB-1:0]     mask_q [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       occ;
   logic              full, empty, push, pop;
   logic [NB-1:0]     fail;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return &c ? c : c + CNT_W'(1);
   endfunction

   assign full          = occ == (AW+1)'(DEPTH);
   assign empty         = occ == '0;
   // A simultaneous pop frees the slot, so a full FIFO still accepts a push.
   assign bus.exp_ready = !full || bus.rsp_valid;
   assign push          = bus.exp_valid && bus.exp_ready;
   assign pop           = bus.rsp_valid && !empty;
   assign occupancy_o   = occ;
   assign idle_o        = empty;

   always_comb begin
      fail = '0;
      for (int b = 0; b < NB; b++)
         fail[b] = mask_q[rd_ptr][b] && (bus.rsp_data[8*b+:8] != data_q[rd_ptr][8*b+:8]);
   end

   always_ff @(posedge clk_i)
      if (push) begin
         data_q[wr_ptr] <= bus.exp_data;
         mask_q[wr_ptr] <= bus.exp_mask;
         addr_q[wr_ptr] <= bus.exp_addr;
      end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         occ              <= '0;
         cmp_valid_o      <= 1'b0;
         mismatch_o       <= 1'b0;
         mismatch_bytes_o <= '0;
         mismatch_addr_o  <= '0;
      end else begin
         wr_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr      <= pop ? rd_ptr + AW'(1) : rd_ptr;
         occ         <= occ + (AW+1)'(push) - (AW+1)'(pop);
         cmp_valid_o <= pop;
         if (pop) begin
            mismatch_o       <= |fail;
            mismatch_bytes_o <= fail;
            mismatch_addr_o  <= addr_q[rd_ptr];
         end
      end

   // Clear overrides any same-cycle statistic or flag update.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         match_count_o    <= '0;
         mismatch_count_o <= '0;
         skip_count_o     <= '0;
         overflow_o       <= 1'b0;
         underflow_o      <= 1'b0;
      end else if (clear_i) begin
         match_count_o    <= '0;
         mismatch_count_o <= '0;
         skip_count_o     <= '0;
         overflow_o       <= 1'b0;
         underflow_o      <= 1'b0;
      end else begin
         if (pop && mask_q[rd_ptr] == '0) skip_count_o <= sat_inc(skip_count_o);
         if (pop && mask_q[rd_ptr] != '0 && |fail) mismatch_count_o <= sat_inc(mismatch_count_o);
         if (pop && mask_q[rd_ptr] != '0 && !(|fail)) match_count_o <= sat_inc(match_count_o);
         if (bus.rsp_valid && empty) underflow_o <= 1'b1;
         if (bus.exp_valid && !bus.exp_ready) overflow_o <= 1'b1;
      end
endmodule

// File: tb/tb_sdram_rd_scoreboard.sv
// tb_sdram_rd_scoreboard: directed plus random stimulus checked against a
// queue-based model of the in-order read scoreboard (DEPTH=8, CNT_W=4).
module tb_sdram_rd_scoreboard;
   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  m;
      logic [31:0] a;
   } ent_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clear_i = 1'b0;
   logic        cmp_valid_o, mismatch_o, overflow_o, underflow_o, idle_o;
   logic [3:0]  mismatch_bytes_o, match_count_o, mismatch_count_o, skip_count_o;
   logic [31:0] mismatch_addr_o;
   logic [3:0]  occupancy_o;

   sdram_rd_scoreboard_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   sdram_rd_scoreboard #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .CNT_W(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus), .clear_i(clear_i),
      .cmp_valid_o(cmp_valid_o), .mismatch_o(mismatch_o),
      .mismatch_bytes_o(mismatch_bytes_o), .mismatch_addr_o(mismatch_addr_o),
      .match_count_o(match_count_o), .mismatch_count_o(mismatch_count_o),
      .skip_count_o(skip_count_o), .overflow_o(overflow_o),
      .underflow_o(underflow_o), .occupancy_o(occupancy_o), .idle_o(idle_o)
   );

   always #5 clk_i = ~clk_i;

   int   n_chk = 0, n_fail = 0;
   ent_t q[$];
   int   mc, mmc, sc;
   bit   ovf, unf, m_cmp, m_mis;
   logic [3:0]  m_bytes;
   logic [31:0] m_addr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int c);
      return (c >= 15) ? 15 : c + 1;
   endfunction

   task automatic model_reset();
      q.delete();
      mc = 0; mmc = 0; sc = 0;
      ovf = 0; unf = 0; m_cmp = 0; m_mis = 0; m_bytes = '0; m_addr = '0;
   endtask

   task automatic check_all();
      chk("cmp_valid", cmp_valid_o, m_cmp);
      chk("mismatch", mismatch_o, m_mis);
      chk("mismatch_bytes", mismatch_bytes_o, m_bytes);
      chk("mismatch_addr", mismatch_addr_o, m_addr);
      chk("match_count", match_count_o, mc);
      chk("mismatch_count", mismatch_count_o, mmc);
      chk("skip_count", skip_count_o, sc);
      chk("overflow", overflow_o, ovf);
      chk("underflow", underflow_o, unf);
      chk("occupancy", occupancy_o, q.size());
      chk("idle", idle_o, q.size() == 0);
   endtask

   // One clock: drive inputs, check ready, advance the model, check outputs.
   task automatic step(input logic ev, input logic [31:0] ed, input logic [3:0] em,
                       input logic [31:0] ea, input logic rv, input logic [31:0] rd,
                       input logic clr);
      ent_t h;
      bit push, pop, rdy;
      logic [3:0] f;
      bus.exp_valid = ev; bus.exp_data = ed; bus.exp_mask = em; bus.exp_addr = ea;
      bus.rsp_valid = rv; bus.rsp_data = rd; clear_i = clr;
      #1;
      rdy = (q.size() != 8) || rv;
      chk("exp_ready", bus.exp_ready, rdy);
      push = ev && rdy;
      pop = rv && q.size() > 0;
      m_cmp = pop;
      if (pop) begin
         h = q[0];
         f = '0;
         for (int b = 0; b < 4; b++)
            f[b] = h.m[b] && (((rd >> (8*b)) & 32'hFF) != ((h.d >> (8*b)) & 32'hFF));
         m_bytes = f; m_mis = |f; m_addr = h.a;
         if (h.m == 0) sc = sat(sc);
         else if (f != 0) mmc = sat(mmc);
         else mc = sat(mc);
      end
      if (rv && q.size() == 0) unf = 1;
      if (ev && !push) ovf = 1;
      if (clr) begin mc = 0; mmc = 0; sc = 0; ovf = 0; unf = 0; end
      if (push) q.push_back('{d: ed, m: em, a: ea});
      if (pop) void'(q.pop_front());
      @(posedge clk_i);
      #1;
      check_all();
   endtask

   task automatic idle_step();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [31:0] hd;
      bus.exp_valid = 0; bus.exp_data = 0; bus.exp_mask = 0; bus.exp_addr = 0;
      bus.rsp_valid = 0; bus.rsp_data = 0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_all();
      chk("reset_ready", bus.exp_ready, 1);
      rst_ni = 1'b1;
      idle_step();

      // match then mismatch
      step(1, 32'hDEADBEEF, 4'hF, 32'h10, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
      chk("match_pulse", cmp_valid_o, 1);
      chk("match_flag", mismatch_o, 0);
      chk("match_count1", match_count_o, 1);
      idle_step();
      chk("pulse_one_cycle", cmp_valid_o, 0);
      step(1, 32'h11223344, 4'hF, 32'h14, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h11AA3344, 0);
      chk("mm_bytes", mismatch_bytes_o, 4'b0100);
      chk("mm_addr", mismatch_addr_o, 32'h14);
      chk("mm_count1", mismatch_count_o, 1);

      // partial mask and skip
      step(1, 32'h000000FF, 4'h1, 32'h18, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'hABCDEFFF, 0);
      chk("partial_match", mismatch_o, 0);
      chk("match_count2", match_count_o, 2);
      step(1, $urandom, 4'h0, 32'h1C, 0, 0, 0);
      step(0, 0, 0, 0, 1, $urandom, 0);
      chk("skip_count1", skip_count_o, 1);
      chk("skip_nomm", mismatch_o, 0);

      // full boundary, overflow, push+pop when full, drain with wrap
      for (int i = 0; i < 8; i++) step(1, $urandom, 4'(i + 1), 32'h100 + 32'(4*i), 0, 0, 0);
      #1 chk("full_not_ready", bus.exp_ready, 0);
      step(1, $urandom, 4'hF, 32'h200, 0, 0, 0);
      chk("overflow_set", overflow_o, 1);
      chk("full_occ", occupancy_o, 8);
      step(1, $urandom, 4'hF, 32'h204, 1, $urandom, 0);
      chk("full_pushpop_occ", occupancy_o, 8);
      chk("full_pushpop_addr", mismatch_addr_o, 32'h100);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, (i % 2) ? q[0].d : $urandom, 0);
      chk("drain_last_addr", mismatch_addr_o, 32'h204);
      chk("drain_idle", idle_o, 1);

      // empty boundary: same-cycle push and response is an underflow
      step(0, 0, 0, 0, 0, 0, 1);
      step(1, 32'hCAFEF00D, 4'hF, 32'h300, 1, 32'hCAFEF00D, 0);
      chk("empty_underflow", underflow_o, 1);
      chk("empty_nopulse", cmp_valid_o, 0);
      chk("empty_occ", occupancy_o, 1);
      step(0, 0, 0, 0, 1, 32'hCAFEF00D, 1);

      // saturation, streamed push+pop each cycle, then clear vs mismatch
      step(1, $urandom, 4'hF, 32'h400, 0, 0, 0);
      for (int i = 0; i < 19; i++) step(1, $urandom, 4'hF, 32'h404 + 32'(4*i), 1, q[0].d, 0);
      step(0, 0, 0, 0, 1, q[0].d, 0);
      chk("sat_match", match_count_o, 15);
      step(1, 32'h55555555, 4'hF, 32'h500, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h55555554, 1);
      chk("clr_match", match_count_o, 0);
      chk("clr_mm", mismatch_count_o, 0);
      chk("clr_pulse", cmp_valid_o, 1);
      chk("clr_mismatch", mismatch_o, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         hd = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0].d : $urandom;
         if ($urandom_range(0, 3) == 0) hd = hd ^ (32'hFF << (8 * $urandom_range(0, 3)));
         step($urandom_range(0, 9) < 6, $urandom, 4'($urandom), $urandom,
              $urandom_range(0, 9) < 5, hd, $urandom_range(0, 39) == 0);
      end

      // reset mid-stream with three entries queued
      while (q.size() > 0) step(0, 0, 0, 0, 1, $urandom, 0);
      for (int i = 0; i < 3; i++) step(1, $urandom, 4'hF, 32'h600 + 32'(i), 0, 0, 0);
      chk("pre_reset_occ", occupancy_o, 3);
      bus.exp_valid = 0; bus.rsp_valid = 0; clear_i = 0;
      rst_ni = 1'b0;
      #2;
      model_reset();
      check_all();
      chk("rst_ready", bus.exp_ready, 1);
      @(posedge clk_i);
      #1;
      check_all();
      rst_ni = 1'b1;
      step(0, 0, 0, 0, 1, $urandom, 0);
      chk("post_reset_underflow", underflow_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
